// File: rtl/fp_normalize_round.sv
// Normalizes and rounds a 27-bit adder mantissa into a packed IEEE-754 single.
// Optional status flags (Overflow/Underflow/Inexact) are enabled by defining NORM_FLAGS_EN.
module fp_normalize_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [26:0] Suma_resul,
  input  logic        Signo_sum,
  input  logic [7:0]  Exponente,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Resultado
`ifdef NORM_FLAGS_EN
  ,
  output logic        Overflow,
  output logic        Underflow,
  output logic        Inexact
`endif
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state_reg, state_next;
  logic [26:0] mant_reg, mant_next;
  logic [9:0]  exp_reg, exp_next;
  logic        sign_reg, sign_next;
  logic [31:0] result_reg, result_next;
  logic        ovf_reg, ovf_next;
  logic        unf_reg, unf_next;
  logic        inex_reg, inex_next;

  // Rounding datapath: round-to-nearest-even on guard/sticky, renormalize on carry-out.
  logic        round_up;
  logic [26:0] rounded;
  logic [26:0] fin_mant;
  logic [9:0]  fin_exp;
  logic        is_inf;
  logic [31:0] packed_res;

  assign round_up = mant_reg[1] & (mant_reg[0] | mant_reg[2]);
  assign rounded  = mant_reg + (round_up ? 27'd4 : 27'd0);
  assign fin_mant = rounded[26] ? {1'b0, rounded[26:2], rounded[1] | rounded[0]} : rounded;
  assign fin_exp  = rounded[26] ? exp_reg + 10'd1 : exp_reg;
  assign is_inf   = (fin_exp >= 10'd255);

  always_comb begin
    packed_res = {sign_reg, exp_reg[7:0], fin_mant[24:2]};
    if (is_inf)
      packed_res = {sign_reg, 8'hFF, 23'h0};
    else if (!fin_mant[25])
      packed_res = {sign_reg, 8'h00, fin_mant[24:2]};
    else
      packed_res = {sign_reg, fin_exp[7:0], fin_mant[24:2]};
  end

  always_comb begin
    state_next  = state_reg;
    mant_next   = mant_reg;
    exp_next    = exp_reg;
    sign_next   = sign_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    unf_next    = unf_reg;
    inex_next   = inex_reg;
    in_ready    = (state_reg == IDLE);
    out_valid   = (state_reg == DONE);

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          mant_next  = Suma_resul;
          sign_next  = Signo_sum;
          exp_next   = {2'b00, Exponente};
          state_next = NORM;
        end
      end
      NORM: begin
        if (mant_reg == 27'd0) begin
          result_next = 32'h0000_0000;
          ovf_next    = 1'b0;
          unf_next    = 1'b0;
          inex_next   = 1'b0;
          state_next  = DONE;
        end else if (mant_reg[26]) begin
          mant_next = {1'b0, mant_reg[26:2], mant_reg[1] | mant_reg[0]};
          exp_next  = exp_reg + 10'd1;
        end else if (!mant_reg[25] && (exp_reg > 10'd1)) begin
          mant_next = {mant_reg[25:0], 1'b0};
          exp_next  = exp_reg - 10'd1;
        end else begin
          state_next = ROUND;
        end
      end
      ROUND: begin
        mant_next   = fin_mant;
        exp_next    = fin_exp;
        result_next = packed_res;
        ovf_next    = is_inf;
        // A denormal that truncates to all-zero fraction is a zero, not an underflow.
        unf_next    = !is_inf && !fin_mant[25] && (fin_mant[24:2] != 23'd0);
        inex_next   = mant_reg[1] | mant_reg[0];
        state_next  = DONE;
      end
      DONE: begin
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      mant_reg   <= '0;
      exp_reg    <= '0;
      sign_reg   <= 1'b0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      inex_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mant_reg   <= mant_next;
      exp_reg    <= exp_next;
      sign_reg   <= sign_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
      inex_reg   <= inex_next;
    end
  end

  assign Resultado = result_reg;

`ifdef NORM_FLAGS_EN
  assign Overflow  = ovf_reg;
  assign Underflow = unf_reg;
  assign Inexact   = inex_reg;
`else
  logic unused_flags;
  assign unused_flags = ovf_reg ^ unf_reg ^ inex_reg;
`endif

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round; latency is counted with the accepting edge as edge 1.
// Flag checks are compiled in when NORM_FLAGS_EN is defined.
module tb_fp_normalize_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] Suma_resul;
  logic        Signo_sum;
  logic [7:0]  Exponente;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Resultado;
`ifdef NORM_FLAGS_EN
  logic        Overflow;
  logic        Underflow;
  logic        Inexact;
`endif

  int compared   = 0;
  int mismatched = 0;

  fp_normalize_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Suma_resul (Suma_resul),
    .Signo_sum  (Signo_sum),
    .Exponente  (Exponente),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Resultado  (Resultado)
`ifdef NORM_FLAGS_EN
    ,
    .Overflow   (Overflow),
    .Underflow  (Underflow),
    .Inexact    (Inexact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Launch one result, measure latency, check value/flags, then complete the handshake.
  task automatic run_op(input string tag, input logic [26:0] sum, input logic sgn,
                        input logic [7:0] ex, input logic [31:0] exp_res,
                        input int exp_lat, input logic [2:0] exp_flags);
    int edges;
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    Suma_resul = sum;
    Signo_sum  = sgn;
    Exponente  = ex;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    Suma_resul = 27'h5A5A5A5;
    edges = 1;
    while (!out_valid && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, edges, exp_lat);
    check({tag, "_result"}, Resultado, exp_res);
`ifdef NORM_FLAGS_EN
    check({tag, "_flags"}, {29'd0, Overflow, Underflow, Inexact}, {29'd0, exp_flags});
`else
    if (exp_flags === 3'bxxx) $display("unused flags");
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    $display("op %s: sum=%h sign=%0d exp=%0d -> %h after %0d edges", tag, sum, sgn, ex, Resultado, edges);
  endtask

  initial begin
    logic [31:0] held;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    Suma_resul = '0;
    Signo_sum  = 1'b0;
    Exponente  = 8'd0;
    #12;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", Resultado, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //       tag         sum           sgn   exp     result          lat  {ovf,unf,inex}
    run_op("two",       27'h4000000, 1'b0, 8'd127, 32'h4000_0000,  4,  3'b000);
    run_op("lshift23",  27'h0000004, 1'b0, 8'd127, 32'h3400_0000, 26,  3'b000);
    run_op("tie_even",  27'h2000002, 1'b0, 8'd127, 32'h3F80_0000,  3,  3'b001);
    run_op("round_up",  27'h2000006, 1'b0, 8'd127, 32'h3F80_0002,  3,  3'b001);
    run_op("sticky_up", 27'h2000003, 1'b0, 8'd127, 32'h3F80_0001,  3,  3'b001);
    run_op("rnd_carry", 27'h3FFFFFE, 1'b0, 8'd127, 32'h4000_0000,  3,  3'b001);
    run_op("neg_inf",   27'h7FFFFFC, 1'b1, 8'd254, 32'hFF80_0000,  4,  3'b101);
    run_op("pos_inf",   27'h4000000, 1'b0, 8'd254, 32'h7F80_0000,  4,  3'b100);
    run_op("negative",  27'h3000000, 1'b1, 8'd130, 32'hC140_0000,  3,  3'b000);
    run_op("zero",      27'h0000000, 1'b1, 8'd127, 32'h0000_0000,  2,  3'b000);
    run_op("denorm",    27'h1000000, 1'b0, 8'd1,   32'h0040_0000,  3,  3'b010);
    run_op("den_shift", 27'h0000004, 1'b0, 8'd2,   32'h0000_0002,  4,  3'b010);
    run_op("den_to_nrm",27'h1FFFFFE, 1'b0, 8'd1,   32'h0080_0000,  3,  3'b001);

    // Hold in DONE with out_ready low while a competing input is offered.
    Suma_resul = 27'h2000000;
    Signo_sum  = 1'b0;
    Exponente  = 8'd127;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    Suma_resul = 27'h4000000;
    Exponente  = 8'd200;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
    end
    check("hold_valid", {31'd0, out_valid}, 32'd1);
    held = Resultado;
    check("hold_value", held, 32'h3F80_0000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_stable", Resultado, 32'h3F80_0000);
      check("hold_in_ready", {30'd0, in_ready, out_valid}, 32'd1);
      $display("hold cycle %0d: Resultado=%h in_ready=%0d", i, Resultado, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release", {30'd0, out_valid, in_ready}, 32'd1);

    // Reset pulse in the middle of a long normalization.
    Suma_resul = 27'h0000004;
    Exponente  = 8'd127;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", Resultado, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      check("midrst_quiet", {31'd0, out_valid}, 32'd0);
    end
    $display("reset during NORM: out_valid stayed low");
    run_op("after_rst", 27'h2000006, 1'b0, 8'd127, 32'h3F80_0002, 3, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below (clock and reset first).
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream adder result valid.
- in_ready  out  1  block can accept a new result.
- Suma_resul  in  27  adder output.
  - bit26 = carry, bit25 = hidden 1, bits24:2 = fraction[22:0], bit1 = guard, bit0 = sticky.
- Signo_sum  in  1  result sign from the adder.
- Exponente  in  8  common (aligned) exponent, 1..254.
- out_valid  out  1  Resultado valid.
- out_ready  in  1  downstream accepts Resultado.
- Resultado  out  32  packed IEEE-754 single: sign, exp[7:0], frac[22:0].

Function
REQ-002 The FSM SHALL have four states: IDLE, NORM, ROUND, DONE; in_ready=1 only in IDLE.
REQ-003 In IDLE, in_valid&&in_ready SHALL capture Suma_resul, Signo_sum and Exponente (zero-extended to a 10-bit internal exponent) and move to NORM.
REQ-004 NORM with mantissa==0 SHALL go to DONE with Resultado=32'h00000000 (+0 regardless of sign).
REQ-005 NORM with bit26=1 SHALL perform one step per cycle and stay in NORM:
- shift right 1;
- new bit0 = old bit1 | old bit0;
- exponent+1.
REQ-006 NORM with bit26=0, bit25=0 and exponent>1 SHALL shift left 1 (0 into bit0), exponent-1, one shift per cycle; maximum 25 left shifts.
REQ-007 NORM with bit25=1, or with exponent==1 and bit25=0 (denormal), SHALL go to ROUND.
REQ-008 ROUND SHALL apply round-to-nearest-even: increment when guard && (sticky || fraction LSB); otherwise truncate.
REQ-009 If rounding carries into bit26, ROUND SHALL shift right 1 and add 1 to the exponent in the same cycle.
REQ-010 Exponent results SHALL be handled as follows:
- exponent >= 255 after rounding: Resultado = {sign, 8'hFF, 23'h0}.
- denormal (bit25=0 after rounding): exponent field 0.
- otherwise: exponent field = exponent[7:0].
REQ-011 ROUND SHALL register Resultado and go to DONE; out_valid=1 only in DONE.
REQ-012 Latency: out_valid SHALL rise on the 3rd rising edge after the accepting edge, plus one edge per normalization shift.
REQ-013 In DONE, Resultado and out_valid SHALL hold stable while out_ready=0; out_valid&&out_ready SHALL return the FSM to IDLE. No new input is accepted on that same edge.
REQ-014 in_valid asserted outside IDLE SHALL be ignored (no capture, no side effect).

Reset
REQ-015 rst_n=0 SHALL immediately force:
- state IDLE;
- in_ready=1, out_valid=0;
- Resultado=32'h0;
- all internal registers 0.
REQ-016 Reset asserted mid-operation (NORM, ROUND or DONE) SHALL discard the in-flight result; after release the block accepts a new input on the first edge.

Configuration
REQ-017 Macro NORM_FLAGS_EN SHALL control status-flag outputs.
- Defined: adds outputs Overflow, Underflow and Inexact (1 bit each).
  - Registered with Resultado and valid with out_valid; cleared by reset.
  - Overflow = infinity produced; Underflow = exponent field 0 with nonzero result; Inexact = guard|sticky nonzero before rounding.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Verification
REQ-018 Suma_resul=27'h4000000, Signo_sum=0, Exponente=127 -> Resultado=32'h40000000 (2.0), out_valid 4 edges after accept.
REQ-019 Suma_resul=27'h0000004, Exponente=127 -> 23 left shifts, Resultado=32'h34000000, out_valid 26 edges after accept.
REQ-020 Exponente=127, rounding cases:
- Suma_resul=27'h2000002 -> Resultado=32'h3F800000 (tie to even, truncated).
- Suma_resul=27'h2000006 -> Resultado=32'h3F800002 (rounded up).
REQ-021 Suma_resul=27'h7FFFFFC, Signo_sum=1, Exponente=254 -> Resultado=32'hFF800000; Overflow=1 when NORM_FLAGS_EN is defined.
REQ-022 Boundary and handshake checks:
- Suma_resul=0 -> Resultado=32'h00000000.
- Hold out_ready=0 for 5 cycles in DONE -> Resultado stable, in_ready=0.
- Pulse rst_n low during NORM -> out_valid stays 0, in_ready=1 immediately.
